// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage that turns the ALU result into a byte,
// halfword or word load/store on a single-outstanding req/ack data bus, and
// returns sign/zero-extended load data to writeback.
// Optional build macro LSU_TIMEOUT_EN adds a REQ-state bus watchdog of
// TIMEOUT_CYCLES cycles that completes the access with a one-cycle fault.

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk_n,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_load,
    input  logic        i_store,
    output logic        o_busy,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The watchdog limit has to fit the 16-bit counter and be non-zero.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
        $error("load_store_unit: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        memReq_q, memReq_d;
    logic        memWe_q, memWe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
    logic [15:0] count_q, count_d;
    logic        timedOut_q, timedOut_d;
`endif

    logic        request;
    logic        isLoad;
    logic        legalF3;
    logic        misaligned;
    logic        idleFault;
    logic        accept;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [31:0] laneWord;
    logic [31:0] loadData;

    // A simultaneous load and store is treated as a load.
    assign request = i_load | i_store;
    assign isLoad  = i_load;

    // Decode access size into byte enables, store lane replication and alignment.
    always_comb begin
        legalF3    = 1'b0;
        misaligned = 1'b0;
        beNext     = 4'b0000;
        wdataNext  = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                beNext    = 4'b0001 << i_addr[1:0];
                wdataNext = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                beNext     = 4'b0011 << {i_addr[1], 1'b0};
                wdataNext  = {2{i_wdata[15:0]}};
                misaligned = i_addr[0];
            end
            2'b10: begin
                beNext     = 4'b1111;
                misaligned = |i_addr[1:0];
            end
            default: begin
                beNext = 4'b0000;
            end
        endcase
        if (isLoad) begin
            legalF3 = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legalF3 = i_funct3 inside {3'b000, 3'b001, 3'b010};
        end
    end

    assign idleFault = (state_q == IDLE) && request && (!legalF3 || misaligned);
    assign accept    = (state_q == IDLE) && request && !idleFault;

    // Shift the addressed lane down to bit 0, then extend according to funct3.
    assign laneWord = i_mem_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b100:  loadData = {24'd0, laneWord[7:0]};
            3'b101:  loadData = {16'd0, laneWord[15:0]};
            default: loadData = laneWord;
        endcase
    end

    // Next-state logic: capture the access in IDLE, wait for ack in REQ, one DONE cycle.
    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memBe_d    = memBe_q;
        memWdata_d = memWdata_q;
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        rdata_d    = rdata_q;
`ifdef LSU_TIMEOUT_EN
        count_d    = count_q;
        timedOut_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    memAddr_d  = {i_addr[31:2], 2'b00};
                    memBe_d    = beNext;
                    memWe_d    = !isLoad;
                    memWdata_d = wdataNext;
                    funct3_d   = i_funct3;
                    offset_d   = i_addr[1:0];
                    memReq_d   = 1'b1;
                    state_d    = REQ;
`ifdef LSU_TIMEOUT_EN
                    count_d    = 16'd0;
`endif
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    memReq_d = 1'b0;
                    rdata_d  = memWe_q ? 32'd0 : loadData;
                    state_d  = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (count_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    memReq_d   = 1'b0;
                    rdata_d    = 32'd0;
                    timedOut_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    count_d = count_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers; reset drops any in-flight access.
    always_ff @(posedge i_clk_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'd0;
            memBe_q    <= 4'd0;
            memWdata_q <= 32'd0;
            funct3_q   <= 3'd0;
            offset_q   <= 2'd0;
            rdata_q    <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            count_q    <= 16'd0;
            timedOut_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memBe_q    <= memBe_d;
            memWdata_q <= memWdata_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            rdata_q    <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            count_q    <= count_d;
            timedOut_q <= timedOut_d;
`endif
        end
    end

    assign o_busy      = (state_q == REQ) || accept;
`ifdef LSU_TIMEOUT_EN
    assign o_fault     = idleFault || timedOut_q;
`else
    assign o_fault     = idleFault;
`endif
    assign o_rdata     = rdata_q;
    assign o_mem_req   = memReq_q;
    assign o_mem_we    = memWe_q;
    assign o_mem_addr  = memAddr_q;
    assign o_mem_be    = memBe_q;
    assign o_mem_wdata = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector scoreboard bench for load_store_unit.
// Stimulus pushes expected bus requests and completions into queues; a
// monitor pops and compares them when the DUT raises or drops o_mem_req,
// or raises o_fault from IDLE. Define LSU_TIMEOUT_EN to add the watchdog vector.

module tb_load_store_unit;

    localparam int unsigned TB_TIMEOUT = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        chkW;
        logic [31:0] wdata;
    } busExp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          busyLen;
    } doneExp_t;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic        i_load = 1'b0;
    logic        i_store = 1'b0;
    logic        o_busy;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;

    busExp_t  busQ[$];
    doneExp_t doneQ[$];

    logic [31:0] respData = 32'd0;
    int          ackDelay = 0;
    logic        forceAck = 1'b0;
    logic        finishReq = 1'b0;

    int vectors = 0;
    int errors = 0;

    load_store_unit #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .i_clk_n    (clk),
        .i_rst_n    (i_rst_n),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_funct3   (i_funct3),
        .i_load     (i_load),
        .i_store    (i_store),
        .o_busy     (o_busy),
        .o_rdata    (o_rdata),
        .o_fault    (o_fault),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_be   (o_mem_be),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial forever #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access for a single cycle and record what the DUT must do with it.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rsp, input int dly,
                                 input logic idleFault, input logic expFault,
                                 input logic [3:0] expBe, input logic chkW,
                                 input logic [31:0] expWdata, input logic [31:0] expRdata,
                                 input int expBusy, input int settle);
        busExp_t  b;
        doneExp_t d;
        respData = rsp;
        ackDelay = dly;
        if (!idleFault) begin
            b.addr  = {addr[31:2], 2'b00};
            b.be    = expBe;
            b.we    = st && !ld;
            b.chkW  = chkW;
            b.wdata = expWdata;
            busQ.push_back(b);
        end
        d.rdata   = expRdata;
        d.fault   = expFault;
        d.busyLen = expBusy;
        doneQ.push_back(d);
        i_load   = ld;
        i_store  = st;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wd;
        tick();
        i_load  = 1'b0;
        i_store = 1'b0;
        repeat (settle) tick();
    endtask

    // Bus slave: ack after ackDelay request cycles (0 = never), or when forced.
    initial begin
        int reqCnt = 0;
        forever begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            if (o_mem_req) reqCnt++;
            else reqCnt = 0;
            if (forceAck || (o_mem_req && ackDelay != 0 && reqCnt == ackDelay)) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = respData;
            end
        end
    end

    // Monitor: compares request fields, completions, held data and reset state.
    initial begin
        logic        rstAtEdge;
        logic        prevReq = 1'b0;
        logic [31:0] holdRdata = 32'd0;
        int          busyRun = 0;
        busExp_t     b;
        doneExp_t    d;
        forever begin
            @(posedge clk);
            rstAtEdge = !i_rst_n;
            @(negedge clk);
            if (finishReq) break;
            if (rstAtEdge) begin
                checkOutput("rst_req", 32'(o_mem_req), 32'd0);
                checkOutput("rst_we", 32'(o_mem_we), 32'd0);
                checkOutput("rst_be", 32'(o_mem_be), 32'd0);
                checkOutput("rst_addr", o_mem_addr, 32'd0);
                checkOutput("rst_wdata", o_mem_wdata, 32'd0);
                checkOutput("rst_rdata", o_rdata, 32'd0);
                checkOutput("rst_busy", 32'(o_busy), 32'd0);
                checkOutput("rst_fault", 32'(o_fault), 32'd0);
                holdRdata = 32'd0;
                busyRun = 0;
            end else begin
                if (o_busy) busyRun++;
                if (o_mem_req && !prevReq) begin
                    checkOutput("bus_pending", 32'(busQ.size() != 0), 32'd1);
                    if (busQ.size() != 0) begin
                        b = busQ.pop_front();
                        checkOutput("mem_addr", o_mem_addr, b.addr);
                        checkOutput("mem_be", 32'(o_mem_be), 32'(b.be));
                        checkOutput("mem_we", 32'(o_mem_we), 32'(b.we));
                        if (b.chkW) checkOutput("mem_wdata", o_mem_wdata, b.wdata);
                    end
                end
                if (o_mem_req) checkOutput("req_busy", 32'(o_busy), 32'd1);
                if ((!o_mem_req && prevReq) || (o_fault && !prevReq && !o_mem_req)) begin
                    checkOutput("done_pending", 32'(doneQ.size() != 0), 32'd1);
                    if (doneQ.size() != 0) begin
                        d = doneQ.pop_front();
                        checkOutput("done_rdata", o_rdata, d.rdata);
                        checkOutput("done_fault", 32'(o_fault), 32'(d.fault));
                        checkOutput("done_busy", 32'(o_busy), 32'd0);
                        checkOutput("busy_cycles", 32'(busyRun), 32'(d.busyLen));
                        holdRdata = d.rdata;
                    end
                    busyRun = 0;
                end else begin
                    checkOutput("hold_rdata", o_rdata, holdRdata);
                    checkOutput("idle_fault", 32'(o_fault), 32'd0);
                    if (!o_busy) busyRun = 0;
                end
            end
            prevReq = o_mem_req;
        end
        checkOutput("bus_leftover", 32'(busQ.size()), 32'd0);
        checkOutput("done_leftover", 32'(doneQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Directed vector sequence.
    initial begin
        busExp_t b;
        $display("[TB] start");
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        //             ld    st    f3      addr          wdata         rsp           dly ifl  ef   be       chkW  expWdata      expRdata      busy settle
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00001004, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF, 3, 4);
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h00000201, 32'h123456AB, 32'h0,        1, 1'b0, 1'b0, 4'b0010, 1'b1, 32'hABABABAB, 32'h00000000, 2, 3);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h00000202, 32'h123456AB, 32'h0,        1, 1'b0, 1'b0, 4'b1100, 1'b1, 32'h56AB56AB, 32'h00000000, 2, 3);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h00000204, 32'hCAFEF00D, 32'h0,        3, 1'b0, 1'b0, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h00000000, 4, 5);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF7F01, 1, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80, 2, 3);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FF7F01, 1, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h0,        32'h00000080, 2, 3);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80FF7F01, 1, 1'b0, 1'b0, 4'b1100, 1'b0, 32'h0,        32'hFFFF80FF, 2, 3);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h00000100, 32'h0,        32'h80FF7F01, 1, 1'b0, 1'b0, 4'b0011, 1'b0, 32'h0,        32'h00007F01, 2, 3);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,        32'h80FF7F01, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0,        32'h0000007F, 2, 3);
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h00000103, 32'hFFFFFFFF, 32'h80FF7F01, 1, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80, 2, 3);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000302, 32'h0,        32'h0,        1, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 0, 1);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h00000301, 32'h0,        32'h0,        1, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 0, 1);
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h00000300, 32'h0,        32'h0,        1, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 0, 1);
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h00000300, 32'h0,        32'h0,        1, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 0, 1);

        // Reset in the second REQ cycle, then a stray ack while IDLE.
        ackDelay = 0;
        b.addr = 32'h00000400; b.be = 4'b1111; b.we = 1'b0; b.chkW = 1'b0; b.wdata = 32'h0;
        busQ.push_back(b);
        i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h00000400;
        tick();
        i_load = 1'b0;
        tick();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        respData = 32'h11111111;
        forceAck = 1'b1;
        tick();
        forceAck = 1'b0;
        repeat (2) tick();

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000404, 32'h0,        32'h55AA55AA, 1, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0,        32'h55AA55AA, 2, 3);
`ifdef LSU_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0,        32'h00000000, 1 + int'(TB_TIMEOUT), int'(TB_TIMEOUT) + 3);
`endif
        repeat (3) tick();
        finishReq = 1'b1;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address and rs2 as store data, and performs one byte, halfword or word load/store over a single-outstanding req/ack data bus.
- Returns sign- or zero-extended load data to writeback.
- Asserts o_busy to stall the pipeline, the same way the ALU stalls on multi-cycle shifts and mul/div.

Parameters:
- TIMEOUT_CYCLES, 255: bus watchdog limit in cycles. Used only when LSU_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- i_clk_n        in   1   clock; all flops update on its rising edge
- i_rst_n        in   1   synchronous reset, active-low
- i_addr         in   32  effective address (ALU o_alu_out)
- i_wdata        in   32  store data (rs2)
- i_funct3       in   3   access size/sign, RV32I encoding
- i_load         in   1   load instruction present this cycle
- i_store        in   1   store instruction present this cycle
- o_busy         out  1   stall request to pipeline
- o_rdata        out  32  extended load result; valid in DONE
- o_fault        out  1   misaligned or illegal-funct3 access
- o_mem_req      out  1   bus request, held until ack
- o_mem_we       out  1   1 = write, 0 = read
- o_mem_addr     out  32  word address, bits [1:0] = 0
- o_mem_be       out  4   byte enables
- o_mem_wdata    out  32  lane-replicated store data
- i_mem_ack      in   1   bus completion, one-cycle pulse
- i_mem_rdata    in   32  read word, valid with i_mem_ack

Behaviour:
- Reset (i_rst_n = 0 at an edge): state IDLE; o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata and o_rdata all 0. o_busy and o_fault are combinational and read 0 while in IDLE with no request.
- Reset wins over every other event, including mid-transaction. Any in-flight request is dropped and a later ack is ignored.
- Request = i_load | i_store. Asserting both at once is illegal and handled as a load.
- Funct3 decode:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - anything else is illegal.
- Fault (combinational, IDLE only): request && (illegal funct3 || halfword with addr[0] = 1 || word with addr[1:0] != 0).
  - o_fault = 1, o_busy = 0, no bus access, state stays IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
  - loads use the same enables with o_mem_we = 0.
- Store data lanes: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- FSM:
  - IDLE: o_busy = request && !fault. On such a request, register addr[31:2],00 / be / we / wdata / funct3 / addr[1:0], set o_mem_req = 1, go to REQ.
  - REQ: o_busy = 1. Outputs held stable. On i_mem_ack:
    - o_mem_req = 0
    - for a load, o_rdata = extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW)
    - for a store, o_rdata = 0
    - go to DONE.
  - DONE: o_busy = 0 for exactly one cycle (pipeline advances), o_rdata held. Next state is IDLE unconditionally. Inputs are ignored in DONE, so the same instruction is not re-issued.
- Latency: request accepted at edge N; o_mem_req high after N. If ack is sampled at edge N+k (k ≥ 1), DONE spans N+k..N+k+1. Minimum is 3 cycles including the IDLE cycle.
- An ack outside REQ is ignored. i_mem_rdata is sampled only on the ack edge.
- o_rdata holds its value through IDLE until the next load/store completes.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle.
  - When the count reaches TIMEOUT_CYCLES without ack: drop o_mem_req, set o_rdata = 0, pulse o_fault for the single DONE cycle, go to DONE.
  - An ack arriving on the same edge as the timeout wins: normal completion, no fault.
- Undefined: no counter; REQ waits for ack indefinitely, and o_fault is purely the combinational IDLE fault.

Test Plan:
- LW addr 0x00001004, ack after 2 REQ cycles, rdata 0xDEADBEEF -> o_mem_addr 0x00001004, be 1111, we 0. o_busy high for 3 cycles, then DONE o_rdata 0xDEADBEEF with o_busy 0.
- LB addr 0x103 / LBU addr 0x103, rdata 0x80FF7F01 -> be 1000; o_rdata 0xFFFFFF80 / 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, wdata 0x123456AB -> o_mem_addr 0x200, be 0010, we 1, o_mem_wdata 0xABABABAB. SH addr 0x202 -> be 1100, wdata 0x56AB56AB.
- LW addr 0x302; SH addr 0x301; funct3 011 load -> each gives o_fault = 1, o_busy = 0, o_mem_req stays 0, state IDLE.
- Reset asserted in the 2nd REQ cycle, ack arrives next cycle -> o_mem_req 0 and o_rdata 0 after the reset edge; ack ignored; a following LW completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> o_mem_req high 4 cycles, then one DONE cycle with o_fault = 1, o_rdata = 0; back to IDLE.
